// File: rtl/refill_arbiter_if.sv
// refill_arbiter_if
//   Bundle of signals between the refill arbiter, its requesters and the
//   memory refill port.
//   modport slave  : arbiter side (samples req/mem handshakes, drives
//                    grant/done/mem_req_valid/beat_idx/busy/err)
//   modport master : requester/memory side (the opposite directions)
//   Signals:
//     req[NUM_REQ]      level request per requester
//     grant[NUM_REQ]    one-hot owner of the refill port, zero when idle
//     done[NUM_REQ]     one-hot, one-cycle completion pulse to the owner
//     mem_req_valid     burst request to memory
//     mem_req_ready     memory accepts the burst request
//     mem_resp_valid    one data beat returned this cycle
//     beat_idx          index of the beat currently returning
//     busy              arbiter not idle
//     err               one-cycle abort pulse (watchdog builds only)
interface refill_arbiter_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned BURST_LEN = 8
);
    localparam int unsigned BW = $clog2(BURST_LEN);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] done;
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic               mem_resp_valid;
    logic [BW-1:0]      beat_idx;
    logic               busy;
    logic               err;

    modport slave (
        input  req, mem_req_ready, mem_resp_valid,
        output grant, done, mem_req_valid, beat_idx, busy, err
    );

    modport master (
        output req, mem_req_ready, mem_resp_valid,
        input  grant, done, mem_req_valid, beat_idx, busy, err
    );
endinterface

// File: rtl/refill_arbiter.sv
// refill_arbiter
//   Round-robin arbiter granting one refill port to NUM_REQ requesters.
//   Each grant runs one memory burst: address handshake, BURST_LEN data
//   beats, then a one-cycle done pulse to the owner.
//   Ports:
//     clk     rising-edge clock
//     resetn  synchronous active-low reset
//     bus     refill_arbiter_if.slave (req, grant, done, mem_req_valid,
//             mem_req_ready, mem_resp_valid, beat_idx, busy, err)
//   Optional feature: define REFILL_ARBITER_TIMEOUT_EN to add a watchdog
//   that aborts a burst after TIMEOUT consecutive beat-less DATA cycles
//   and pulses err; without it err is tied low and DATA waits forever.
module refill_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic            clk,
    input  logic            resetn,
    refill_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned BW = $clog2(BURST_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [PW-1:0] PTR_RST   = PW'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 16 || BURST_LEN < 2 || BURST_LEN > 16 ||
        (BURST_LEN & (BURST_LEN - 1)) != 0 || TIMEOUT == 0) begin : g_cfg_check
        $error("refill_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

    state_e             state_q;
    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      owner_q;
    logic [BW-1:0]      cnt_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic               mem_req_valid_q;
    logic               busy_q;

`ifdef REFILL_ARBITER_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    logic [WW-1:0] wd_q;
    logic          err_q;
`endif

    // Round-robin pick: first requester above ptr, else lowest overall.
    logic [NUM_REQ-1:0] win_oh;
    logic [PW-1:0]      win_idx;
    logic               win_found;

    always_comb begin
        win_oh    = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!win_found && bus.req[i] && (PW'(i) > ptr_q)) begin
                win_oh[i] = 1'b1;
                win_idx   = PW'(i);
                win_found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!win_found && bus.req[i]) begin
                win_oh[i] = 1'b1;
                win_idx   = PW'(i);
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= IDLE;
            ptr_q           <= PTR_RST;
            owner_q         <= '0;
            cnt_q           <= '0;
            grant_q         <= '0;
            done_q          <= '0;
            mem_req_valid_q <= 1'b0;
            busy_q          <= 1'b0;
`ifdef REFILL_ARBITER_TIMEOUT_EN
            wd_q            <= '0;
            err_q           <= 1'b0;
`endif
        end else begin
            done_q <= '0;
`ifdef REFILL_ARBITER_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        grant_q         <= win_oh;
                        owner_q         <= win_idx;
                        mem_req_valid_q <= 1'b1;
                        busy_q          <= 1'b1;
                        state_q         <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        cnt_q           <= '0;
`ifdef REFILL_ARBITER_TIMEOUT_EN
                        wd_q            <= '0;
`endif
                        state_q         <= DATA;
                    end
                end
                DATA: begin
                    if (bus.mem_resp_valid) begin
                        // Counter wraps to 0 on the last beat (BURST_LEN is a
                        // power of two), so beat_idx reads 0 again in DONE.
                        cnt_q <= cnt_q + BW'(1);
`ifdef REFILL_ARBITER_TIMEOUT_EN
                        wd_q  <= '0;
`endif
                        if (cnt_q == LAST_BEAT) begin
                            done_q  <= grant_q;
                            state_q <= DONE;
                        end
                    end
`ifdef REFILL_ARBITER_TIMEOUT_EN
                    else if (wd_q == WD_LAST) begin
                        // Abandon the burst: no done pulse, owner still
                        // moves to the back of the rotation.
                        err_q   <= 1'b1;
                        grant_q <= '0;
                        ptr_q   <= owner_q;
                        cnt_q   <= '0;
                        wd_q    <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        wd_q <= wd_q + WW'(1);
                    end
`endif
                end
                DONE: begin
                    ptr_q   <= owner_q;
                    grant_q <= '0;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant         = grant_q;
    assign bus.done          = done_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.beat_idx      = cnt_q;
    assign bus.busy          = busy_q;
`ifdef REFILL_ARBITER_TIMEOUT_EN
    assign bus.err           = err_q;
`else
    assign bus.err           = 1'b0;
`endif
endmodule

// File: tb/tb_refill_arbiter.sv
// tb_refill_arbiter
//   Bench for refill_arbiter with NUM_REQ=4, BURST_LEN=4, TIMEOUT=10.
//   Hand-written vector table, directed corner sequences and random
//   traffic, all compared against a transaction-level reference model.
module tb_refill_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned BL = 4;
    localparam int unsigned TO = 10;
    localparam int unsigned BW = $clog2(BL);

    logic clk = 1'b0;
    logic resetn;

    refill_arbiter_if #(.NUM_REQ(N), .BURST_LEN(BL)) bus ();

    refill_arbiter #(.NUM_REQ(N), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: owner index (-1 = none), last served index,
    // beats received, address-phase flag, done-cycle flag, silent count.
    int m_owner  = -1;
    int m_last   = N - 1;
    int m_beats  = 0;
    int m_silent = 0;
    bit m_wait   = 1'b0;
    bit m_done   = 1'b0;
    bit m_err    = 1'b0;

    typedef struct {
        logic          rn;
        logic [N-1:0]  req;
        logic          rdy;
        logic          rsp;
        logic [N-1:0]  g;
        logic [N-1:0]  d;
        logic          mrv;
        logic [BW-1:0] beat;
        logic          busy;
    } vec_t;

    vec_t         tbl[$];
    logic [N-1:0] gseen[5];
    logic [N-1:0] gexp[5];
    int           ng;
    logic         prev_busy;
    int           err_at;

    // Rotate from the requester after the last one served.
    function automatic int pick(logic [N-1:0] r, int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step();
        m_err = 1'b0;
        if (!resetn) begin
            m_owner = -1; m_last = N - 1; m_beats = 0;
            m_silent = 0; m_wait = 1'b0; m_done = 1'b0;
        end else if (m_owner < 0) begin
            if (bus.req != '0) begin
                m_owner = pick(bus.req, m_last);
                m_wait  = 1'b1;
                m_beats = 0;
            end
        end else if (m_done) begin
            m_last  = m_owner;
            m_owner = -1;
            m_done  = 1'b0;
            m_beats = 0;
        end else if (m_wait) begin
            if (bus.mem_req_ready) begin
                m_wait   = 1'b0;
                m_silent = 0;
            end
        end else if (bus.mem_resp_valid) begin
            m_beats++;
            m_silent = 0;
            if (m_beats == BL) m_done = 1'b1;
        end else begin
`ifdef REFILL_ARBITER_TIMEOUT_EN
            m_silent++;
            if (m_silent == TO) begin
                m_err    = 1'b1;
                m_last   = m_owner;
                m_owner  = -1;
                m_beats  = 0;
                m_silent = 0;
            end
`endif
        end
    endtask

    task automatic check(string name);
        logic [N-1:0]  eg;
        logic [N-1:0]  ed;
        logic          emrv;
        logic [BW-1:0] eb;
        logic          ebusy;
        eg    = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        ed    = m_done ? eg : '0;
        emrv  = (m_owner >= 0) && m_wait;
        eb    = BW'(m_beats % BL);
        ebusy = (m_owner >= 0);
        n_vec++;
        if (bus.grant !== eg || bus.done !== ed || bus.mem_req_valid !== emrv ||
            bus.beat_idx !== eb || bus.busy !== ebusy || bus.err !== m_err) begin
            n_miss++;
            $display("FAIL %s t=%0t got grant=%b done=%b mrv=%b beat=%0d busy=%b err=%b expected grant=%b done=%b mrv=%b beat=%0d busy=%b err=%b",
                     name, $time, bus.grant, bus.done, bus.mem_req_valid, bus.beat_idx,
                     bus.busy, bus.err, eg, ed, emrv, eb, ebusy, m_err);
        end
    endtask

    task automatic expect_val(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(logic rn, logic [N-1:0] r, logic rdy, logic rsp);
        resetn             = rn;
        bus.req            = r;
        bus.mem_req_ready  = rdy;
        bus.mem_resp_valid = rsp;
    endtask

    task automatic tick(string name);
        @(posedge clk);
        model_step();
        #1;
        check(name);
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        tick("reset");
    endtask

    task automatic run_burst(logic [N-1:0] r);
        drive(1'b1, r, 1'b0, 1'b0);
        tick("burst_arb");
        drive(1'b1, '0, 1'b1, 1'b0);
        tick("burst_ack");
        for (int b = 0; b < BL; b++) begin
            drive(1'b1, '0, 1'b0, 1'b1);
            tick("burst_beat");
        end
        drive(1'b1, '0, 1'b0, 1'b0);
        tick("burst_idle");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);

        // Single burst from requester 2 with stray handshakes, then a wrap.
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{1'b1, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b1, 2'd0, 1'b1});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b1, 2'd0, 1'b1});
        tbl.push_back('{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd0, 1'b1});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0, 2'd1, 1'b1});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b1});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0, 2'd3, 1'b1});
        tbl.push_back('{1'b1, 4'b0000, 1'b1, 1'b1, 4'b0100, 4'b0100, 1'b0, 2'd0, 1'b1});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{1'b1, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{1'b1, 4'b1011, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b1, 2'd0, 1'b1});
        tbl.push_back('{1'b1, 4'b0011, 1'b1, 1'b0, 4'b1000, 4'b0000, 1'b0, 2'd0, 1'b1});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rn, tbl[i].req, tbl[i].rdy, tbl[i].rsp);
            @(posedge clk);
            model_step();
            #1;
            n_vec++;
            if (bus.grant !== tbl[i].g || bus.done !== tbl[i].d ||
                bus.mem_req_valid !== tbl[i].mrv || bus.beat_idx !== tbl[i].beat ||
                bus.busy !== tbl[i].busy || bus.err !== 1'b0) begin
                n_miss++;
                $display("FAIL table[%0d] got grant=%b done=%b mrv=%b beat=%0d busy=%b err=%b expected grant=%b done=%b mrv=%b beat=%0d busy=%b err=0",
                         i, bus.grant, bus.done, bus.mem_req_valid, bus.beat_idx, bus.busy,
                         bus.err, tbl[i].g, tbl[i].d, tbl[i].mrv, tbl[i].beat, tbl[i].busy);
            end
        end

        // All requesters held: strict rotation starting at requester 0.
        do_reset();
        drive(1'b1, 4'b1111, 1'b1, 1'b1);
        gexp[0] = 4'b0001; gexp[1] = 4'b0010; gexp[2] = 4'b0100;
        gexp[3] = 4'b1000; gexp[4] = 4'b0001;
        for (int k = 0; k < 5; k++) gseen[k] = '0;
        ng = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            tick("rr_hold");
            if (bus.busy && !prev_busy) begin
                gseen[ng] = bus.grant;
                ng++;
            end
            prev_busy = bus.busy;
        end
        for (int k = 0; k < 5; k++) expect_val("rr_order", 32'(gseen[k]), 32'(gexp[k]));

        // Owner drops its request mid-burst while requester 0 asks.
        do_reset();
        drive(1'b1, 4'b0100, 1'b0, 1'b0);
        tick("drop_arb");
        drive(1'b1, 4'b0100, 1'b1, 1'b0);
        tick("drop_ack");
        drive(1'b1, 4'b0001, 1'b0, 1'b1);
        for (int b = 0; b < BL; b++) tick("drop_beat");
        expect_val("drop_done", 32'(bus.done), 32'(4'b0100));
        expect_val("drop_grant_held", 32'(bus.grant), 32'(4'b0100));
        drive(1'b1, 4'b0001, 1'b0, 1'b0);
        tick("drop_idle");
        expect_val("drop_idle_grant", 32'(bus.grant), 32'(4'b0000));
        tick("drop_next");
        expect_val("drop_next_grant", 32'(bus.grant), 32'(4'b0001));

        // Reset during beat 2 must also restore the rotation pointer.
        do_reset();
        run_burst(4'b0010);
        drive(1'b1, 4'b1000, 1'b0, 1'b0);
        tick("rst_arb");
        drive(1'b1, '0, 1'b1, 1'b0);
        tick("rst_ack");
        drive(1'b1, '0, 1'b0, 1'b1);
        tick("rst_beat0");
        tick("rst_beat1");
        expect_val("rst_beat_idx", 32'(bus.beat_idx), 32'd2);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick("rst_mid");
        expect_val("rst_outputs", {bus.grant, bus.done, bus.mem_req_valid, bus.busy, bus.err,
                                   bus.beat_idx}, 32'd0);
        drive(1'b1, 4'b1010, 1'b0, 1'b0);
        tick("rst_rearb");
        expect_val("rst_first_grant", 32'(bus.grant), 32'(4'b0010));

        // Silent memory after the address phase.
        do_reset();
        drive(1'b1, 4'b0001, 1'b0, 1'b0);
        tick("silent_arb");
        drive(1'b1, '0, 1'b1, 1'b0);
        tick("silent_ack");
        drive(1'b1, '0, 1'b0, 1'b0);
`ifdef REFILL_ARBITER_TIMEOUT_EN
        err_at = -1;
        for (int c = 1; c <= 3 * TO; c++) begin
            tick("timeout_wait");
            if (bus.err === 1'b1 && err_at < 0) err_at = c;
            expect_val("timeout_no_done", 32'(bus.done), 32'd0);
        end
        expect_val("timeout_err_cycle", 32'(err_at), 32'(TO));
`else
        err_at = 0;
        for (int c = 1; c <= 3 * TO; c++) tick("no_timeout_wait");
        expect_val("no_timeout_grant", 32'(bus.grant), 32'(4'b0001));
        expect_val("no_timeout_err", 32'(bus.err), 32'(err_at));
`endif
        do_reset();
        drive(1'b1, '0, 1'b1, 1'b1);
        tick("stray_idle");
        tick("stray_idle");
        expect_val("stray_beat_idx", 32'(bus.beat_idx), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive(logic'($urandom_range(0, 199) != 0), N'($urandom),
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 9) < 7));
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
